sensor_conditioner: RTL and testbench

- Upstream stage of the irrigation controller. Conditions the six raw field inputs before the alarm/valve/irrigation logic and the display drivers use them.
- Raw inputs: tank level high/medium/low, inverted temperature, soil humidity, air humidity.
- Each bit passes through a 2-flop synchroniser and a per-bit stable-count debouncer.
- Also provides a post-reset warm-up qualifier, so downstream logic never acts on unsettled sensors.

---
 rtl/sensor_conditioner.sv | 153 +++++++++++++++
 tb/tb_sensor_conditioner.sv | 172 +++++++++++++++++
 2 files changed

// File: rtl/sensor_conditioner.sv
// Conditions the raw irrigation field inputs: 2-flop synchroniser, per-bit
// stable-count debouncer, post-reset warm-up qualifier and tank-level sanity flag.
module sensor_conditioner #(
    parameter int N_INPUTS        = 6,
    parameter int DEBOUNCE_CYCLES = 50000,
    parameter int CNT_W           = 16
) (
    input  logic                clock,
    input  logic                reset,
    input  logic [N_INPUTS-1:0] rawSensors,
    output logic [N_INPUTS-1:0] sensorsStable,
    output logic [N_INPUTS-1:0] changePulse,
    output logic                sensorsValid,
    output logic                levelInconsistent
);

    localparam logic [CNT_W-1:0] LAST_COUNT = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_ZERO   = {CNT_W{1'b0}};
    localparam logic [N_INPUTS-1:0] BITS_ZERO = {N_INPUTS{1'b0}};

    typedef enum logic [0:0] {
        WARMUP = 1'b0,
        RUN    = 1'b1
    } state_t;

    // Tank levels must nest: high implies medium, medium implies low.
    function automatic logic levelCheck(input logic [2:0] levels);
        return (levels[2] & ~levels[1]) | (levels[1] & ~levels[0]);
    endfunction

    logic [N_INPUTS-1:0] sync1_r;
    logic [N_INPUTS-1:0] sync2_r;
    state_t              state_r;
    state_t              stateNext_s;
    logic [CNT_W-1:0]    warmCnt_r;
    logic [CNT_W-1:0]    warmCntNext_s;
    logic [CNT_W-1:0]    bitCnt_r     [N_INPUTS];
    logic [CNT_W-1:0]    bitCntNext_s [N_INPUTS];
    logic [N_INPUTS-1:0] stableNext_s;
    logic [N_INPUTS-1:0] pulseNext_s;
    logic                validNext_s;
    logic                inconsistentNext_s;
    logic                warmDone_s;

    assign warmDone_s = (warmCnt_r >= LAST_COUNT);

    // FSM state register.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_r <= WARMUP;
        end else begin
            state_r <= stateNext_s;
        end
    end

    // FSM next-state logic; RUN is left only through reset.
    always_comb begin
        stateNext_s = state_r;
        case (state_r)
            WARMUP: begin
                if (warmDone_s) begin
                    stateNext_s = RUN;
                end else begin
                    stateNext_s = WARMUP;
                end
            end
            RUN:     stateNext_s = RUN;
            default: stateNext_s = WARMUP;
        endcase
    end

    // FSM output logic: next values for counters and the registered outputs.
    always_comb begin
        stableNext_s  = sensorsStable;
        pulseNext_s   = BITS_ZERO;
        validNext_s   = sensorsValid;
        warmCntNext_s = warmCnt_r;
        bitCntNext_s  = bitCnt_r;
        case (state_r)
            WARMUP: begin
                validNext_s  = 1'b0;
                stableNext_s = BITS_ZERO;
                if (warmDone_s) begin
                    // Initial load reflects the field silently: no change strobe.
                    stableNext_s = sync2_r;
                    validNext_s  = 1'b1;
                    for (int i = 0; i < N_INPUTS; i++) begin
                        bitCntNext_s[i] = CNT_ZERO;
                    end
                end else begin
                    warmCntNext_s = warmCnt_r + CNT_ONE;
                end
            end
            RUN: begin
                validNext_s = 1'b1;
                for (int i = 0; i < N_INPUTS; i++) begin
                    if (sync2_r[i] == sensorsStable[i]) begin
                        // Any agreeing cycle restarts the count, rejecting glitches.
                        bitCntNext_s[i] = CNT_ZERO;
                    end else if (bitCnt_r[i] >= LAST_COUNT) begin
                        stableNext_s[i] = sync2_r[i];
                        bitCntNext_s[i] = CNT_ZERO;
                        pulseNext_s[i]  = 1'b1;
                    end else begin
                        bitCntNext_s[i] = bitCnt_r[i] + CNT_ONE;
                    end
                end
            end
            default: begin
                stableNext_s  = BITS_ZERO;
                validNext_s   = 1'b0;
                warmCntNext_s = CNT_ZERO;
                for (int i = 0; i < N_INPUTS; i++) begin
                    bitCntNext_s[i] = CNT_ZERO;
                end
            end
        endcase
        if (validNext_s) begin
            inconsistentNext_s = levelCheck(stableNext_s[2:0]);
        end else begin
            inconsistentNext_s = 1'b0;
        end
    end

    // Synchroniser, counters and registered outputs.
    always_ff @(posedge clock) begin
        if (reset) begin
            sync1_r           <= BITS_ZERO;
            sync2_r           <= BITS_ZERO;
            warmCnt_r         <= CNT_ZERO;
            sensorsStable     <= BITS_ZERO;
            changePulse       <= BITS_ZERO;
            sensorsValid      <= 1'b0;
            levelInconsistent <= 1'b0;
            for (int i = 0; i < N_INPUTS; i++) begin
                bitCnt_r[i] <= CNT_ZERO;
            end
        end else begin
            sync1_r           <= rawSensors;
            sync2_r           <= sync1_r;
            warmCnt_r         <= warmCntNext_s;
            sensorsStable     <= stableNext_s;
            changePulse       <= pulseNext_s;
            sensorsValid      <= validNext_s;
            levelInconsistent <= inconsistentNext_s;
            for (int i = 0; i < N_INPUTS; i++) begin
                bitCnt_r[i] <= bitCntNext_s[i];
            end
        end
    end

endmodule

// File: tb/tb_sensor_conditioner.sv
// Scoreboard bench for sensor_conditioner with DEBOUNCE_CYCLES=4: expected
// per-cycle outputs are queued when stimulus is applied and checked on negedge.
module tb_sensor_conditioner;

    localparam int DEB = 4;
    localparam int LAT = DEB + 2;

    logic       clock = 1'b0;
    logic       reset;
    logic [5:0] rawSensors;
    logic [5:0] sensorsStable;
    logic [5:0] changePulse;
    logic       sensorsValid;
    logic       levelInconsistent;

    int cycle  = 0;
    int checks = 0;
    int errors = 0;

    typedef struct {
        int         cyc;
        logic [5:0] stable;
        logic [5:0] pulse;
        logic       valid;
        logic       incons;
    } exp_t;

    exp_t sb[$];

    sensor_conditioner #(
        .N_INPUTS(6),
        .DEBOUNCE_CYCLES(DEB),
        .CNT_W(16)
    ) dut (
        .clock(clock),
        .reset(reset),
        .rawSensors(rawSensors),
        .sensorsStable(sensorsStable),
        .changePulse(changePulse),
        .sensorsValid(sensorsValid),
        .levelInconsistent(levelInconsistent)
    );

    always #5 clock = ~clock;

    always @(posedge clock) cycle <= cycle + 1;

    task automatic checkVal(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("FAIL %s @cycle %0d: got %0h expected %0h", tag, cycle, actual, expected);
        end
    endtask

    task automatic pushExp(input int cyc, input logic [5:0] s, input logic [5:0] p,
                           input logic v, input logic inc);
        exp_t e;
        e.cyc = cyc; e.stable = s; e.pulse = p; e.valid = v; e.incons = inc;
        sb.push_back(e);
    endtask

    // A clean raw change applied just after edge k lands after edge k+LAT.
    task automatic expectChange(input int k, input logic [5:0] oldS, input logic [5:0] newS,
                                input logic [5:0] pulse, input logic incOld, input logic incNew);
        for (int d = 1; d < LAT; d++) pushExp(k + d, oldS, 6'b000000, 1'b1, incOld);
        pushExp(k + LAT, newS, pulse, 1'b1, incNew);
        pushExp(k + LAT + 1, newS, 6'b000000, 1'b1, incNew);
    endtask

    task automatic waitDrain();
        for (int n = 0; n < 60; n++) begin
            if (sb.size() == 0) break;
            @(posedge clock);
        end
        checkVal("drain timeout", sb.size(), 0);
        sb.delete();
        @(posedge clock);
        #1;
    endtask

    // Scoreboard monitor, sampling away from the active edge.
    always @(negedge clock) begin
        exp_t e;
        if (sb.size() > 0) begin
            if (sb[0].cyc < cycle) begin
                checkVal("sb missed", cycle, sb[0].cyc);
                void'(sb.pop_front());
            end else if (sb[0].cyc == cycle) begin
                e = sb.pop_front();
                checkVal("stable", {26'd0, sensorsStable}, {26'd0, e.stable});
                checkVal("pulse", {26'd0, changePulse}, {26'd0, e.pulse});
                checkVal("valid", {31'd0, sensorsValid}, {31'd0, e.valid});
                checkVal("incons", {31'd0, levelInconsistent}, {31'd0, e.incons});
            end
        end
    end

    initial begin
        #50000;
        $display("FAIL watchdog @cycle %0d: got timeout expected finish", cycle);
        $fatal(1);
    end

    initial begin
        int k;
        reset      = 1'b1;
        rawSensors = 6'b000111;
        repeat (3) @(posedge clock);
        #1;
        reset = 1'b0;
        k = cycle;
        // Warm-up: zero for the reset cycle and DEB-1 more, then loaded.
        for (int d = 0; d < DEB; d++) pushExp(k + d, 6'b000000, 6'b000000, 1'b0, 1'b0);
        pushExp(k + DEB, 6'b000111, 6'b000000, 1'b1, 1'b0);
        pushExp(k + DEB + 1, 6'b000111, 6'b000000, 1'b1, 1'b0);
        waitDrain();

        // Soil humidity rises.
        k = cycle;
        rawSensors = 6'b010111;
        expectChange(k, 6'b000111, 6'b010111, 6'b010000, 1'b0, 1'b0);
        waitDrain();

        // Three-cycle glitch on the low-level bit is rejected.
        k = cycle;
        rawSensors = 6'b010110;
        for (int d = 1; d <= 12; d++) pushExp(k + d, 6'b010111, 6'b000000, 1'b1, 1'b0);
        repeat (3) @(posedge clock);
        #1;
        rawSensors = 6'b010111;
        waitDrain();

        // High level falls and air humidity rises on the same edge.
        k = cycle;
        rawSensors = 6'b110011;
        expectChange(k, 6'b010111, 6'b110011, 6'b100100, 1'b0, 1'b0);
        waitDrain();

        // High without medium is inconsistent.
        k = cycle;
        rawSensors = 6'b110101;
        expectChange(k, 6'b110011, 6'b110101, 6'b000110, 1'b0, 1'b1);
        waitDrain();

        // Restoring medium clears the flag.
        k = cycle;
        rawSensors = 6'b110111;
        expectChange(k, 6'b110101, 6'b110111, 6'b000010, 1'b1, 1'b0);
        waitDrain();

        // Reset two cycles into a pending debounce, then full warm-up again.
        k = cycle;
        rawSensors = 6'b111111;
        for (int d = 1; d <= 4; d++) pushExp(k + d, 6'b110111, 6'b000000, 1'b1, 1'b0);
        repeat (4) @(posedge clock);
        #1;
        reset = 1'b1;
        @(posedge clock);
        #1;
        reset = 1'b0;
        k = cycle;
        for (int d = 0; d < DEB; d++) pushExp(k + d, 6'b000000, 6'b000000, 1'b0, 1'b0);
        pushExp(k + DEB, 6'b111111, 6'b000000, 1'b1, 1'b0);
        pushExp(k + DEB + 1, 6'b111111, 6'b000000, 1'b1, 1'b0);
        waitDrain();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
